// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE/ISSUE/RESP FSM with registered outputs and a wait-cycle timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_err,
    output logic              m1_err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err0_q, err0_d;
    logic              err1_q, err1_d;
    logic              busy_q, busy_d;
    logic              err_pend_q, err_pend_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              grant;
`ifdef MEM_ARB_RR_EN
    logic              last_q, last_d;
`endif

    // Winner among current requests; only meaningful when at least one is high.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (m0_req && m1_req) begin
            grant = ~last_q;
        end else begin
            grant = ~m0_req;
        end
`else
        grant = ~m0_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_pend_q <= 1'b0;
            cnt_q      <= '0;
`ifdef MEM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            busy_q     <= busy_d;
            err_pend_q <= err_pend_d;
            cnt_q      <= cnt_d;
`ifdef MEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        busy_d     = busy_q;
        err_pend_d = err_pend_q;
        cnt_d      = cnt_q;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif

        unique case (state_q)
            StIdle: begin
                rd_d   = 1'b0;
                wr_d   = 1'b0;
                busy_d = 1'b0;
                if (m0_req || m1_req) begin
                    owner_d = grant;
                    we_d    = grant ? m1_we : m0_we;
                    addr_d  = grant ? m1_addr : m0_addr;
                    wdata_d = grant ? m1_wdata : m0_wdata;
                    rd_d    = ~(grant ? m1_we : m0_we);
                    wr_d    = grant ? m1_we : m0_we;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StIssue;
`ifdef MEM_ARB_RR_EN
                    last_d  = grant;
`endif
                end
            end
            StIssue: begin
                // mem_ready takes precedence over a coincident timeout.
                if (mem_ready || (cnt_q == TimeoutVal)) begin
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    ack0_d     = ~owner_q;
                    ack1_d     = owner_q;
                    err_pend_d = ~mem_ready;
                    err0_d     = ~owner_q & ~mem_ready;
                    err1_d     = owner_q & ~mem_ready;
                    if (mem_ready && !we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                err_pend_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_err    = err0_q;
    assign m1_err    = err1_q;
    assign rdata     = rdata_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, memory data width in bits.
REQ-003 Parameter TIMEOUT, default 15, maximum ISSUE cycles spent waiting for mem_ready; legal range 1..255.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 m0_req, m1_req  input  1  requester N transaction request; held high until mN_ack.
REQ-007 m0_we, m1_we  input  1  requester N direction; 1 = write, 0 = read.
REQ-008 m0_addr, m1_addr  input  ADDR_W  requester N address.
REQ-009 m0_wdata, m1_wdata  input  DATA_W  requester N write data.
REQ-010 m0_ack, m1_ack  output  1  requester N transaction complete; single-cycle pulse.
REQ-011 m0_err, m1_err  output  1  requester N timeout flag; valid only with mN_ack.
REQ-012 rdata  output  DATA_W  read data of the last completed read, shared by both requesters.
REQ-013 mem_read  output  1  memory read command.
REQ-014 mem_write  output  1  memory write command.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data; valid when mem_ready is high.
REQ-018 mem_ready  input  1  memory completes the current command.
REQ-019 busy  output  1  high whenever state is not IDLE.
REQ-020 owner  output  1  index of the granted requester; held stable from grant until return to IDLE.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE and RESP; every output SHALL be registered.
REQ-022 IDLE, any mN_req high: choose winner, latch its we/addr/wdata, set owner, go to ISSUE; mem_read/mem_write assert on the first ISSUE cycle.
REQ-023 IDLE, no request: remain in IDLE with mem_read = mem_write = 0.
REQ-024 ISSUE: mem_read = ~we and mem_write = we; mem_addr and mem_wdata held stable until mem_ready is sampled high; mem_ready on the first ISSUE cycle is legal.
REQ-025 ISSUE with mem_ready high: deassert the command, capture mem_rdata into rdata on reads only (writes leave rdata unchanged), go to RESP.
REQ-026 Wait counter: clear on entry to ISSUE; increment on each ISSUE cycle without mem_ready; on the cycle it equals TIMEOUT with no mem_ready, deassert the command, set a pending error, go to RESP.
REQ-027 mem_ready and timeout in the same cycle: mem_ready wins, no error.
REQ-028 RESP: assert m[owner]_ack for exactly one cycle, with m[owner]_err = pending error; then go to IDLE and clear the pending error.
REQ-029 The non-owner's request and data SHALL be ignored until IDLE; a requester that drops mN_req mid-transaction does not abort it.
REQ-030 A request still high in IDLE after its ack is a new transaction.
REQ-031 Minimum transaction time with zero-wait memory SHALL be 3 cycles, from the request being sampled in IDLE to the ack.
REQ-032 Round-robin: on simultaneous requests, grant the requester not served last; a single requester is always granted.

Reset
REQ-033 rst high: state IDLE; all outputs 0 (rdata included); wait counter 0; pending error cleared; last-served pointer = 1, so port 0 wins the first tie.
REQ-034 rst during ISSUE or RESP SHALL drop the command and any pending ack at that edge; no ack is issued for the aborted transaction.

Configuration
REQ-035 Macro MEM_ARB_RR_EN defined: round-robin per REQ-032.
REQ-036 MEM_ARB_RR_EN undefined: fixed priority, port 0 always wins simultaneous requests; the last-served pointer is not implemented; all other behaviour is identical.

Verification
REQ-037 Single read: m0_req, we=0, addr=8'h10, mem_ready on the first ISSUE cycle, mem_rdata=32'hDEADBEEF -> m0_ack 3 cycles after the request is sampled; rdata=32'hDEADBEEF; m0_err=0.
REQ-038 Write with 4 wait cycles: m1 writes 32'h12345678 to addr 8'h20 -> mem_write high for 5 cycles with addr and data stable; m1_ack follows; rdata unchanged.
REQ-039 Contention, RR_EN defined: m0 and m1 held high continuously -> grants alternate 0,1,0,1; undefined -> port 0 always granted.
REQ-040 Timeout: mem_ready held 0, TIMEOUT=15 -> command drops after 16 ISSUE cycles; m0_ack=1 and m0_err=1 in the same cycle; the next transaction has err=0.
REQ-041 rst asserted in the 2nd ISSUE cycle -> next cycle all outputs 0, state IDLE, no ack; a fresh request then completes normally.
